// File: rtl/e203_lsu_req_arbt_pkg.sv
// Shared constants for the LSU request arbiter: requester IDs and default sizing.
package e203_lsu_req_arbt_pkg;

   localparam logic        E203_LSU_ARBT_ID_AGU     = 1'b0;
   localparam logic        E203_LSU_ARBT_ID_NICE    = 1'b1;
   localparam int unsigned E203_LSU_ARBT_OUTS_DEPTH = 2;
   localparam int unsigned E203_LSU_ARBT_AW         = 32;
   localparam int unsigned E203_LSU_ARBT_DW         = 32;

endpackage

// File: rtl/e203_lsu_arbt_outs_fifo.sv
// Outstanding-command ID FIFO (1 bit wide, DEPTH deep).
//   clk, rst      : clock, asynchronous active-high reset
//   push_i/din_i  : write the requester ID of an accepted command (caller keeps push off when full)
//   pop_i         : retire the head entry on a response handshake (caller keeps pop off when empty)
//   full_o/empty_o: occupancy flags
//   head_o        : ID of the oldest outstanding command
module e203_lsu_arbt_outs_fifo #(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  logic pop_i,
   input  logic din_i,
   output logic full_o,
   output logic empty_o,
   output logic head_o
);

   generate
      if (DEPTH == 1) begin : g_one
         // Single entry: a valid flag replaces the pointer pair.
         logic vld_q, vld_d;
         logic dat_q, dat_d;

         always_comb begin
            vld_d = vld_q;
            dat_d = dat_q;
            if (push_i) begin
               vld_d = 1'b1;
               dat_d = din_i;
            end else if (pop_i) begin
               vld_d = 1'b0;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld_q <= 1'b0;
               dat_q <= 1'b0;
            end else begin
               vld_q <= vld_d;
               dat_q <= dat_d;
            end
         end

         assign full_o  = vld_q;
         assign empty_o = ~vld_q;
         assign head_o  = dat_q;
      end else begin : g_multi
         localparam int unsigned PW = $clog2(DEPTH);

         // Pointers carry one extra wrap bit to tell full from empty.
         logic [DEPTH-1:0] mem_q, mem_d;
         logic [PW:0]      wptr_q, wptr_d;
         logic [PW:0]      rptr_q, rptr_d;

         always_comb begin
            mem_d  = mem_q;
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            if (push_i) begin
               mem_d[wptr_q[PW-1:0]] = din_i;
               wptr_d = wptr_q + (PW+1)'(1);
            end
            if (pop_i) begin
               rptr_d = rptr_q + (PW+1)'(1);
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               mem_q  <= '0;
               wptr_q <= '0;
               rptr_q <= '0;
            end else begin
               mem_q  <= mem_d;
               wptr_q <= wptr_d;
               rptr_q <= rptr_d;
            end
         end

         assign empty_o = (wptr_q == rptr_q);
         assign full_o  = (wptr_q[PW] != rptr_q[PW]) &&
                          (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
         assign head_o  = mem_q[rptr_q[PW-1:0]];
      end
   endgenerate

endmodule

// File: rtl/e203_lsu_req_arbt.sv
// Two-requester ICB arbiter in front of the LSU command port.
// Requester 0 = AGU, requester 1 = NICE memory port. Responses return in order
// and are routed by the ID FIFO head.
// Optional macro E203_LSU_ARBT_RR_EN: round-robin grant (default: NICE over AGU).
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   nice_mem_holdup       : NICE asks for exclusive use of the LSU path
//   r0_cmd_* / r1_cmd_*   : requester command channels
//   r0_rsp_* / r1_rsp_*   : requester response channels
//   o_cmd_* / o_rsp_*     : shared channel to LSU control
//   arbt_active           : any command pending or response outstanding
module e203_lsu_req_arbt
   import e203_lsu_req_arbt_pkg::*;
#(
   parameter int unsigned AW         = E203_LSU_ARBT_AW,
   parameter int unsigned DW         = E203_LSU_ARBT_DW,
   parameter int unsigned OUTS_DEPTH = E203_LSU_ARBT_OUTS_DEPTH
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            nice_mem_holdup,

   input  logic            r0_cmd_valid,
   output logic            r0_cmd_ready,
   input  logic [AW-1:0]   r0_cmd_addr,
   input  logic            r0_cmd_read,
   input  logic [DW-1:0]   r0_cmd_wdata,
   input  logic [DW/8-1:0] r0_cmd_wmask,
   input  logic [1:0]      r0_cmd_size,
   output logic            r0_rsp_valid,
   input  logic            r0_rsp_ready,
   output logic            r0_rsp_err,
   output logic [DW-1:0]   r0_rsp_rdata,

   input  logic            r1_cmd_valid,
   output logic            r1_cmd_ready,
   input  logic [AW-1:0]   r1_cmd_addr,
   input  logic            r1_cmd_read,
   input  logic [DW-1:0]   r1_cmd_wdata,
   input  logic [DW/8-1:0] r1_cmd_wmask,
   input  logic [1:0]      r1_cmd_size,
   output logic            r1_rsp_valid,
   input  logic            r1_rsp_ready,
   output logic            r1_rsp_err,
   output logic [DW-1:0]   r1_rsp_rdata,

   output logic            o_cmd_valid,
   input  logic            o_cmd_ready,
   output logic [AW-1:0]   o_cmd_addr,
   output logic            o_cmd_read,
   output logic [DW-1:0]   o_cmd_wdata,
   output logic [DW/8-1:0] o_cmd_wmask,
   output logic [1:0]      o_cmd_size,
   input  logic            o_rsp_valid,
   output logic            o_rsp_ready,
   input  logic            o_rsp_err,
   input  logic [DW-1:0]   o_rsp_rdata,

   output logic            arbt_active
);

   logic fifo_full, fifo_empty, fifo_head;
   logic fifo_push, fifo_pop;
   logic gnt_id, gnt_vld;
   logic lock_q, lock_d;
   logic lock_id_q, lock_id_d;
   logic cmd_hsk;
   logic elig0, elig1;

`ifdef E203_LSU_ARBT_RR_EN
   logic ptr_q, ptr_d;
`endif

   assign elig0 = r0_cmd_valid & ~nice_mem_holdup;
   assign elig1 = r1_cmd_valid;

   // Grant: a locked grant keeps its requester (even under holdup) so the
   // payload stays stable until the handshake.
   always_comb begin
      gnt_id  = E203_LSU_ARBT_ID_AGU;
      gnt_vld = 1'b0;
      if (lock_q) begin
         gnt_id  = lock_id_q;
         gnt_vld = lock_id_q ? r1_cmd_valid : r0_cmd_valid;
      end else begin
         gnt_vld = elig0 | elig1;
`ifdef E203_LSU_ARBT_RR_EN
         if (elig0 & elig1) gnt_id = ptr_q;
         else               gnt_id = elig1;
`else
         gnt_id = elig1;
`endif
      end
   end

   // Full FIFO blocks the command path outright; no push-on-pop when full.
   assign o_cmd_valid  = gnt_vld & ~fifo_full;
   assign cmd_hsk      = o_cmd_valid & o_cmd_ready;
   assign r0_cmd_ready = o_cmd_ready & o_cmd_valid & (gnt_id == E203_LSU_ARBT_ID_AGU);
   assign r1_cmd_ready = o_cmd_ready & o_cmd_valid & (gnt_id == E203_LSU_ARBT_ID_NICE);

   assign o_cmd_addr  = gnt_id ? r1_cmd_addr  : r0_cmd_addr;
   assign o_cmd_read  = gnt_id ? r1_cmd_read  : r0_cmd_read;
   assign o_cmd_wdata = gnt_id ? r1_cmd_wdata : r0_cmd_wdata;
   assign o_cmd_wmask = gnt_id ? r1_cmd_wmask : r0_cmd_wmask;
   assign o_cmd_size  = gnt_id ? r1_cmd_size  : r0_cmd_size;

   // Lock next state: set on a stalled command, cleared on handshake.
   always_comb begin
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      if (o_cmd_valid & ~o_cmd_ready) begin
         lock_d    = 1'b1;
         lock_id_d = gnt_id;
      end else if (cmd_hsk) begin
         lock_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_q    <= 1'b0;
         lock_id_q <= E203_LSU_ARBT_ID_AGU;
      end else begin
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
      end
   end

`ifdef E203_LSU_ARBT_RR_EN
   // Round-robin pointer hands the tie to the requester not just served.
   always_comb begin
      ptr_d = ptr_q;
      if (cmd_hsk) ptr_d = ~gnt_id;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= E203_LSU_ARBT_ID_AGU;
      else     ptr_q <= ptr_d;
   end
`endif

   assign fifo_push = cmd_hsk;
   assign fifo_pop  = o_rsp_valid & o_rsp_ready;

   e203_lsu_arbt_outs_fifo #(
      .DEPTH (OUTS_DEPTH)
   ) u_outs_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .din_i   (gnt_id),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head)
   );

   // Response routing by head ID; an empty FIFO stalls any spurious response.
   assign r0_rsp_valid = o_rsp_valid & ~fifo_empty & (fifo_head == E203_LSU_ARBT_ID_AGU);
   assign r1_rsp_valid = o_rsp_valid & ~fifo_empty & (fifo_head == E203_LSU_ARBT_ID_NICE);
   assign o_rsp_ready  = ~fifo_empty & (fifo_head ? r1_rsp_ready : r0_rsp_ready);

   assign r0_rsp_err   = o_rsp_err;
   assign r1_rsp_err   = o_rsp_err;
   assign r0_rsp_rdata = o_rsp_rdata;
   assign r1_rsp_rdata = o_rsp_rdata;

   assign arbt_active = r0_cmd_valid | r1_cmd_valid | ~fifo_empty;

endmodule
